seq_magnitude_comparator: RTL and testbench

- Multi-cycle, parametrised successor to the calculator's 4-bit combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, and stops early at the first differing chunk.
- Supports signed and unsigned operands and uses valid/ready handshakes on input and output.
- Keeps the calculator's 8-bit result code, so the display path is unchanged.

---
 rtl/seq_magnitude_comparator_pkg.sv | 15 +
 rtl/seq_magnitude_comparator_chunk_cmp.sv | 25 ++
 rtl/seq_magnitude_comparator.sv | 151 +++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared result codes and FSM state type for the sequential magnitude comparator.
package cmp_pkg;

  localparam logic [7:0] CMP_NONE = 8'h00;
  localparam logic [7:0] CMP_GT   = 8'h01;
  localparam logic [7:0] CMP_LT   = 8'h02;
  localparam logic [7:0] CMP_EQ   = 8'h03;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/seq_magnitude_comparator_chunk_cmp.sv
// Combinational CHUNK-bit comparator; invert_msb turns the unsigned compare into a two's-complement one.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             invert_msb,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  always_comb begin
    flip            = '0;
    flip[CHUNK-1]   = invert_msb;
    a_x             = a_chunk ^ flip;
    b_x             = b_chunk ^ flip;
    gt              = (a_x > b_x);
    lt              = (a_x < b_x);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with valid/ready handshakes and early exit.
// Optional min_out/max_out ports are enabled by defining CMP_MINMAX_EN.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic                        signed_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  result,
  output logic [$clog2(NCHUNK+1)-1:0] cycles
`ifdef CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0]            min_out,
  output logic [WIDTH-1:0]            max_out
`endif
);

  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW = $clog2(NCHUNK + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [7:0]       res_q, res_d;
`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
`endif

  logic [CHUNK-1:0] ca, cb;
  logic             top_chunk;
  logic             gt, lt;

  always_comb begin
    ca        = a_q[int'(k_q) * CHUNK +: CHUNK];
    cb        = b_q[int'(k_q) * CHUNK +: CHUNK];
    top_chunk = (k_q == KW'(NCHUNK - 1));
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_chunk    (ca),
    .b_chunk    (cb),
    .invert_msb (signed_q & top_chunk),
    .gt         (gt),
    .lt         (lt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    k_d      = k_q;
    cyc_d    = cyc_q;
    res_d    = res_q;
`ifdef CMP_MINMAX_EN
    min_d    = min_q;
    max_d    = max_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          k_d      = KW'(NCHUNK - 1);
          cyc_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (gt || lt || (k_q == '0)) begin
          res_d   = gt ? CMP_GT : (lt ? CMP_LT : CMP_EQ);
          state_d = DONE;
`ifdef CMP_MINMAX_EN
          // The first differing chunk decides the order, so it also picks min/max.
          min_d = gt ? b_q : a_q;
          max_d = lt ? b_q : a_q;
`endif
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d   = CMP_NONE;
          state_d = IDLE;
`ifdef CMP_MINMAX_EN
          min_d   = '0;
          max_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      k_q      <= '0;
      cyc_q    <= '0;
      res_q    <= CMP_NONE;
`ifdef CMP_MINMAX_EN
      min_q    <= '0;
      max_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      k_q      <= k_d;
      cyc_q    <= cyc_d;
      res_q    <= res_d;
`ifdef CMP_MINMAX_EN
      min_q    <= min_d;
      max_q    <= max_d;
`endif
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = res_q;
    cycles    = cyc_q;
`ifdef CMP_MINMAX_EN
    min_out   = min_q;
    max_out   = max_q;
`endif
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomized and directed self-checking bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
module tb_seq_magnitude_comparator;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          signed_mode;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    result;
  logic [2:0]    cycles;
`ifdef CMP_MINMAX_EN
  logic [W-1:0]  min_out;
  logic [W-1:0]  max_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   exp_res;
  int           exp_cyc;
  logic [W-1:0] exp_min, exp_max;
  logic [W-1:0] last_min, last_max;

  seq_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .cycles      (cycles)
`ifdef CMP_MINMAX_EN
    ,
    .min_out     (min_out),
    .max_out     (max_out)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: whole-word arithmetic compare.
  function automatic logic [7:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    if (x == y) return 8'h03;
    if (sm) return ($signed(x) > $signed(y)) ? 8'h01 : 8'h02;
    return (x > y) ? 8'h01 : 8'h02;
  endfunction

  // Cycles used = number of chunks scanned down to the highest differing one.
  function automatic int model_cyc(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = W - 1; i >= 0; i--)
      if (d[i]) return NC - (i / C);
    return NC;
  endfunction

  // Continuous compare of result/cycles against the model whenever a result is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        chk("mon_result", {24'd0, result}, {24'd0, exp_res});
        chk("mon_cycles", {29'd0, cycles}, exp_cyc);
        chk("mon_in_ready_busy", {31'd0, in_ready}, 32'd0);
`ifdef CMP_MINMAX_EN
        chk("mon_min", {16'd0, min_out}, {16'd0, exp_min});
        chk("mon_max", {16'd0, max_out}, {16'd0, exp_max});
`endif
      end else begin
        chk("mon_result_idle", {24'd0, result}, 32'd0);
`ifdef CMP_MINMAX_EN
        if (in_ready) begin
          chk("mon_min_idle", {16'd0, min_out}, 32'd0);
          chk("mon_max_idle", {16'd0, max_out}, 32'd0);
        end
`endif
      end
    end
  end

  // Called at posedge+1 with the DUT idle. lr/lc < 0 skip the literal checks.
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic sm,
                         input int hold, input int lr, input int lc);
    int lat;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    exp_res = model_res(ta, tbv, sm);
    exp_cyc = model_cyc(ta, tbv);
    if (exp_res == 8'h03) begin
      exp_min = ta; exp_max = ta;
    end else if (exp_res == 8'h01) begin
      exp_min = tbv; exp_max = ta;
    end else begin
      exp_min = ta; exp_max = tbv;
    end
    a = ta; b = tbv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'($urandom);
    a           = W'($urandom);
    b           = W'($urandom);
    signed_mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat <= NC + 1) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
      rst_n = 1'b0; #2 rst_n = 1'b1;
      @(posedge clk); #1;
      return;
    end
    chk("latency", lat, exp_cyc);
    if (lr >= 0) chk("lit_result", {24'd0, result}, lr);
    if (lc >= 0) chk("lit_cycles", {29'd0, cycles}, lc);
`ifdef CMP_MINMAX_EN
    last_min = min_out;
    last_max = max_out;
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_result", {24'd0, result}, {24'd0, exp_res});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_result", {24'd0, result}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sel;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    exp_res = '0; exp_cyc = 0; exp_min = '0; exp_max = '0;
    last_min = '0; last_max = '0;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_cycles", {29'd0, cycles}, 32'd0);
    #17 rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmp(16'hA000, 16'h9FFF, 1'b0, 0, 8'h01, 1);
    run_cmp(16'h1234, 16'h1234, 1'b0, 0, 8'h03, 4);
    run_cmp(16'h8000, 16'h0001, 1'b1, 0, 8'h02, 1);
    run_cmp(16'h8000, 16'h0001, 1'b0, 0, 8'h01, 1);
    run_cmp(16'h0013, 16'h0012, 1'b0, 5, 8'h01, 4);
    run_cmp(16'hFFFE, 16'h0003, 1'b1, 1, 8'h02, 1);
`ifdef CMP_MINMAX_EN
    chk("lit_min_signed", {16'd0, last_min}, 32'h0000FFFE);
    chk("lit_max_signed", {16'd0, last_max}, 32'h00000003);
`endif
    run_cmp(16'hFFFE, 16'h0003, 1'b0, 1, 8'h01, 1);
`ifdef CMP_MINMAX_EN
    chk("lit_min_unsigned", {16'd0, last_min}, 32'h00000003);
    chk("lit_max_unsigned", {16'd0, last_max}, 32'h0000FFFE);
`endif
    run_cmp(16'h7FF0, 16'h7FF1, 1'b1, 0, 8'h02, 4);

    // Reset in the middle of a compare.
    a = 16'hFFFF; b = 16'hFFFF; signed_mode = 1'b0; in_valid = 1'b1;
    exp_res = 8'h03; exp_cyc = NC; exp_min = a; exp_max = a;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", {24'd0, result}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_cycles", {29'd0, cycles}, 32'd0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    end

    for (int i = 0; i < 60; i++) begin
      ra  = W'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (W'($urandom_range(1, 15)) << (C * $urandom_range(0, NC - 1)));
      endcase
      run_cmp(ra, rb, 1'($urandom), $urandom_range(0, 3), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
